prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Boot-time program/data loader upstream of CPU_SingleCycle. Consumes a byte stream (UART/host
//  side), writes 32-bit words into instruction memory and data memory through their write ports,
//  holds the CPU in reset while loading, releases it on a GO command. Replaces direct memory pokes.
// PARAMETERS
//  IM_AW  8   instruction-memory word-address width
//  DM_AW  10  data-memory word-address width (word addr = byte addr >> 2)
//  DW     32  memory word width; fixed at 32, 4 bytes per word
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous, active-low reset
//  rx_data   in   8      stream byte
//  rx_valid  in   1      rx_data valid
//  rx_ready  out  1      loader accepts byte; transfer = rx_valid & rx_ready
//  im_we     out  1      one-cycle IM write strobe
//  im_addr   out  IM_AW  IM word address
//  im_wdata  out  DW     IM write data
//  dm_we     out  1      one-cycle DM write strobe
//  dm_addr   out  DM_AW  DM word address
//  dm_wdata  out  DW     DM write data
//  cpu_rst   out  1      active-high reset to CPU (1 = held)
//  busy      out  1      block transfer in progress (HDR/DATA/CSUM)
//  err       out  1      sticky protocol/checksum error
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cpu_rst=1, im_we=dm_we=0, addrs/wdata=0, busy=0, err=0,
//   rx_ready=0; rx_ready=1 from first clock after release in every state.
//  Frame: CMD, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT*4 data bytes big-endian (MSB first)[, CSUM].
//  CMD: 0x49 'I' -> IM block; 0x44 'D' -> DM block; 0x47 'G' -> RUN; other -> ERR.
//  States: IDLE -CMD I/D-> HDR (4 bytes) -> DATA (CNT==0: skip DATA) -> [CSUM] -> IDLE;
//   IDLE -G-> RUN; IDLE -bad CMD-> ERR.
//  ADDR is a word address, truncated to IM_AW/DM_AW bits; CNT is 16-bit unsigned.
//  Word write: on the cycle after the 4th byte of a word is accepted, selected *_we=1 for exactly
//   one cycle with addr/wdata stable; addr then increments by 1 modulo 2^AW (wraps, no error).
//  Only the selected memory is written; the other *_we stays 0.
//  RUN: cpu_rst=0 from the cycle after 'G' accepted; bytes accepted and ignored except 0x48 'H'
//   -> IDLE with cpu_rst=1 next cycle (allows reload). cpu_rst=1 in every state but RUN.
//  ERR: err=1, cpu_rst=1, all bytes drained (rx_ready=1) and ignored; exit only by reset.
//  busy=1 in HDR/DATA/CSUM. rx_valid without ready has no effect; stalls are unbounded.
//  Reset mid-block: partial word discarded, no write strobe, state IDLE.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: CSUM byte follows data; must equal XOR of all frame bytes CMD..
//   last data byte; mismatch -> ERR (already-written words remain); match -> IDLE.
//  Undefined: no CSUM state; DATA (or HDR when CNT==0) returns directly to IDLE.
// STRUCTURE
//  Package loader_pkg: CMD_IM/CMD_DM/CMD_GO/CMD_HALT byte constants, state encoding localparams.
//  Sub-module byte_packer: shifts 4 bytes into a 32-bit word, flags word_done; reset on frame start.
//  Top: FSM, header regs, word counter, address counter, checksum accumulator.
// TESTING
//  1 'I',00,00,00,03 + 3 words -> im_we pulses x3, im_addr 0,1,2, data matches; dm_we never 1.
//  2 'D',00,80,00,01,00,00,00,37 -> single dm_we, dm_addr=0x080 (byte 512), dm_wdata=0x37.
//  3 'G' after loads -> cpu_rst 1->0 next cycle; then 'H' -> cpu_rst=1 next cycle, state IDLE.
//  4 CMD 0x5A -> err=1, cpu_rst stays 1, later 'G' ignored; rst low clears err.
//  5 'I' ADDR=0x00FF CNT=2 -> writes at im_addr 255 then 0 (wrap); rx_valid gaps change nothing.
//  6 rst low after 2 data bytes -> no strobe, outputs at reset values; fresh frame loads correctly.
//  7 (LOADER_CHECKSUM_EN) correct CSUM -> err=0; flipped CSUM bit -> err=1, state ERR.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared command bytes and FSM state type for the boot-time program loader.
package loader_pkg;

    localparam logic [7:0] CMD_IM   = 8'h49;  // 'I'
    localparam logic [7:0] CMD_DM   = 8'h44;  // 'D'
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles four big-endian bytes into a 32-bit word; word_done_o marks the 4th byte push.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (push_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Word is presented combinationally with the 4th byte so the top can register it directly.
    assign word_o      = {shift_q, byte_i};
    assign word_done_o = push_i && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream loader for IM/DM with CPU reset control.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
    import loader_pkg::*;
#(
    parameter int IM_AW = 8,
    parameter int DM_AW = 10,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [DW-1:0]    im_wdata,
    output logic             dm_we,
    output logic [DM_AW-1:0] dm_addr,
    output logic [DW-1:0]    dm_wdata,
    output logic             cpu_rst,
    output logic             busy,
    output logic             err
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e ST_AFTER = ST_CSUM;
`else
    localparam state_e ST_AFTER = ST_IDLE;
`endif

    state_e             state_q, state_d;
    logic [23:0]        hdr_q, hdr_d;
    logic [1:0]         hcnt_q, hcnt_d;
    logic [15:0]        words_q, words_d;
    logic               sel_im_q, sel_im_d;
    logic [IM_AW-1:0]   im_addr_q, im_addr_d;
    logic [DM_AW-1:0]   dm_addr_q, dm_addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rx_ready_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic        xfer;
    logic [31:0] hdr_full;
    logic        pk_clr, pk_push, pk_done;
    logic [31:0] pk_word;

    assign xfer     = rx_valid && rx_ready_q;
    assign hdr_full = {hdr_q, rx_data};

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (pk_clr),
        .push_i     (pk_push),
        .byte_i     (rx_data),
        .word_o     (pk_word),
        .word_done_o(pk_done)
    );

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        hcnt_d    = hcnt_q;
        words_d   = words_q;
        sel_im_d  = sel_im_q;
        im_addr_d = im_addr_q;
        dm_addr_d = dm_addr_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        pk_clr    = 1'b0;
        pk_push   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        // Address advances during the strobe cycle so addr is stable while *_we is high.
        if (we_q) begin
            if (sel_im_q) im_addr_d = im_addr_q + 1'b1;
            else          dm_addr_d = dm_addr_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: if (xfer) begin
                pk_clr = 1'b1;
                hcnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                csum_d = rx_data;
`endif
                case (rx_data)
                    CMD_IM: begin sel_im_d = 1'b1; state_d = ST_HDR; end
                    CMD_DM: begin sel_im_d = 1'b0; state_d = ST_HDR; end
                    CMD_GO:  state_d = ST_RUN;
                    default: state_d = ST_ERR;
                endcase
            end
            ST_HDR: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                csum_d = csum_q ^ rx_data;
`endif
                hdr_d  = {hdr_q[15:0], rx_data};
                hcnt_d = hcnt_q + 2'd1;
                if (hcnt_q == 2'd3) begin
                    words_d = hdr_full[15:0];
                    if (sel_im_q) im_addr_d = IM_AW'(hdr_full[31:16]);
                    else          dm_addr_d = DM_AW'(hdr_full[31:16]);
                    state_d = (hdr_full[15:0] == 16'd0) ? ST_AFTER : ST_DATA;
                end
            end
            ST_DATA: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                csum_d  = csum_q ^ rx_data;
`endif
                pk_push = 1'b1;
                if (pk_done) begin
                    we_d    = 1'b1;
                    wdata_d = pk_word;
                    words_d = words_q - 16'd1;
                    if (words_q == 16'd1) state_d = ST_AFTER;
                end
            end
            ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) state_d = (rx_data == csum_q) ? ST_IDLE : ST_ERR;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RUN: if (xfer && rx_data == CMD_HALT) state_d = ST_IDLE;
            ST_ERR: state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            hcnt_q     <= '0;
            words_q    <= '0;
            sel_im_q   <= 1'b0;
            im_addr_q  <= '0;
            dm_addr_q  <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            hcnt_q     <= hcnt_d;
            words_q    <= words_d;
            sel_im_q   <= sel_im_d;
            im_addr_q  <= im_addr_d;
            dm_addr_q  <= dm_addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rx_ready_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rx_ready = rx_ready_q;
    assign im_we    = we_q && sel_im_q;
    assign dm_we    = we_q && !sel_im_q;
    assign im_addr  = im_addr_q;
    assign dm_addr  = dm_addr_q;
    assign im_wdata = wdata_q;
    assign dm_wdata = wdata_q;
    assign cpu_rst  = (state_q != ST_RUN);
    assign busy     = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; define LOADER_CHECKSUM_EN to also cover the checksum byte.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    int          im_a[$];
    logic [31:0] im_d[$];
    int          dm_a[$];
    logic [31:0] dm_d[$];
    logic [31:0] wq[$];
    logic [7:0]  cs_acc;

    always #5 clk = ~clk;

    prog_loader #(.IM_AW(8), .DM_AW(10), .DW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .im_we   (im_we),
        .im_addr (im_addr),
        .im_wdata(im_wdata),
        .dm_we   (dm_we),
        .dm_addr (dm_addr),
        .dm_wdata(dm_wdata),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .err     (err)
    );

    always @(negedge clk) begin
        if (im_we) begin
            im_a.push_back(int'(im_addr));
            im_d.push_back(im_wdata);
        end
        if (dm_we) begin
            dm_a.push_back(int'(dm_addr));
            dm_d.push_back(dm_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        im_a.delete(); im_d.delete(); dm_a.delete(); dm_d.delete();
    endtask

    // Byte handshake: returns at 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        cs_acc   = cs_acc ^ b;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [15:0] addr, input int gap,
                         input bit bad_csum);
        logic [15:0] cnt;
        logic [31:0] w;
        cnt    = 16'(wq.size());
        cs_acc = 8'h00;
        send(cmd, 0);
        send(addr[15:8], gap);
        send(addr[7:0], gap);
        send(cnt[15:8], gap);
        send(cnt[7:0], gap);
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            for (int k = 3; k >= 0; k--) send(w[8*k +: 8], gap);
        end
        check("we_next_cycle", {31'd0, (cmd == 8'h49) ? im_we : dm_we}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
        send(bad_csum ? (cs_acc ^ 8'h01) : cs_acc, gap);
`else
        if (bad_csum) check("bad_csum_unsupported", 32'd1, {31'd0, err});
`endif
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cs_acc   = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("rst_we",       {30'd0, im_we, dm_we}, 32'd0);
        check("rst_busy_err", {30'd0, busy, err}, 32'd0);
        check("rst_addrs",    {14'd0, dm_addr, im_addr}, 32'd0);
        check("rst_wdata",    im_wdata | dm_wdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'd0, rx_ready}, 32'd1);

        // 1: three IM words at 0,1,2
        clear_logs();
        wq = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        frame(8'h49, 16'h0000, 0, 1'b0);
        check("t1_im_count", 32'(im_a.size()), 32'd3);
        check("t1_dm_count", 32'(dm_a.size()), 32'd0);
        if (im_a.size() == 3) begin
            check("t1_a0", 32'(im_a[0]), 32'd0);
            check("t1_d0", im_d[0], 32'h11223344);
            check("t1_a1", 32'(im_a[1]), 32'd1);
            check("t1_d1", im_d[1], 32'h55667788);
            check("t1_a2", 32'(im_a[2]), 32'd2);
            check("t1_d2", im_d[2], 32'h99AABBCC);
        end
        check("t1_idle", {29'd0, busy, err, cpu_rst}, 32'd1);

        // 2: one DM word at word address 0x080
        clear_logs();
        wq = '{32'h00000037};
        frame(8'h44, 16'h0080, 0, 1'b0);
        check("t2_dm_count", 32'(dm_a.size()), 32'd1);
        check("t2_im_count", 32'(im_a.size()), 32'd0);
        if (dm_a.size() == 1) begin
            check("t2_addr", 32'(dm_a[0]), 32'h080);
            check("t2_data", dm_d[0], 32'h00000037);
        end

        // 3: GO releases CPU, other bytes ignored, HALT re-asserts
        check("t3_pre_go", {31'd0, cpu_rst}, 32'd1);
        send(8'h47, 0);
        check("t3_go", {31'd0, cpu_rst}, 32'd0);
        send(8'h49, 0);
        send(8'h12, 1);
        check("t3_run_ignore", {29'd0, cpu_rst, busy, err}, 32'd0);
        send(8'h48, 0);
        check("t3_halt", {29'd0, cpu_rst, busy, err}, 32'b100);

        // 5: address wrap with valid gaps
        clear_logs();
        wq = '{32'hA1B2C3D4, 32'hCAFEF00D};
        frame(8'h49, 16'h00FF, 2, 1'b0);
        check("t5_im_count", 32'(im_a.size()), 32'd2);
        if (im_a.size() == 2) begin
            check("t5_a0", 32'(im_a[0]), 32'd255);
            check("t5_d0", im_d[0], 32'hA1B2C3D4);
            check("t5_a1", 32'(im_a[1]), 32'd0);
            check("t5_d1", im_d[1], 32'hCAFEF00D);
        end
        check("t5_im_addr_after", {24'd0, im_addr}, 32'd1);

        // 4: bad command locks into error
        send(8'h5A, 0);
        check("t4_err", {30'd0, err, cpu_rst}, 32'b11);
        send(8'h47, 0);
        check("t4_go_ignored", {29'd0, err, cpu_rst, rx_ready}, 32'b111);
        rst = 1'b0;
        #1;
        check("t4_rst_clears", {30'd0, err, cpu_rst}, 32'b01);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // 6: reset mid-word discards partial data
        clear_logs();
        send(8'h49, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0); send(8'h01, 0);
        check("t6_busy", {31'd0, busy}, 32'd1);
        check("t6_addr_loaded", {24'd0, im_addr}, 32'h10);
        send(8'hAA, 0); send(8'hBB, 0);
        rst = 1'b0;
        #1;
        check("t6_rst_outs", {27'd0, im_we, dm_we, busy, cpu_rst, rx_ready}, 32'b00010);
        check("t6_rst_addr", {24'd0, im_addr}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("t6_no_strobe", 32'(im_a.size() + dm_a.size()), 32'd0);
        wq = '{32'hDEADBEEF};
        frame(8'h44, 16'h0005, 0, 1'b0);
        check("t6_dm_count", 32'(dm_a.size()), 32'd1);
        if (dm_a.size() == 1) begin
            check("t6_addr", 32'(dm_a[0]), 32'd5);
            check("t6_data", dm_d[0], 32'hDEADBEEF);
        end

`ifdef LOADER_CHECKSUM_EN
        // 7: checksum good then bad
        clear_logs();
        wq = '{32'h0BADF00D};
        frame(8'h44, 16'h0003, 0, 1'b0);
        check("t7_good_err", {30'd0, err, busy}, 32'd0);
        wq = '{32'h01020304};
        frame(8'h49, 16'h0001, 0, 1'b1);
        check("t7_bad_err", {29'd0, err, cpu_rst, busy}, 32'b110);
        check("t7_written", 32'(im_a.size()), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
